// File: rtl/dfc_param_if.sv
// Handshake and data bundle between the sample source, dfc_param and the downstream packer.
// The master side drives load data, commands and out_ready.
// The slave side (dfc_param) drives the pair results and status.
interface dfc_param_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] datain;
    logic              data_valid;
    logic [1:0]        cmd;
    logic              cmd_valid;
    logic              out_ready;
    logic [DATA_W:0]   dataout;
    logic              output_valid;
    logic              busy;

    modport master (
        output datain,
        output data_valid,
        output cmd,
        output cmd_valid,
        output out_ready,
        input  dataout,
        input  output_valid,
        input  busy
    );

    modport slave (
        input  datain,
        input  data_valid,
        input  cmd,
        input  cmd_valid,
        input  out_ready,
        output dataout,
        output output_valid,
        output busy
    );
endinterface

// File: rtl/dfc_param.sv
// dfc_param: parametrised data-fetch/combine controller.
// LOAD fills DEPTH words. FIFO and LIFO stream the DEPTH/2 sums word[k] + word[k+DEPTH/2].
// FIFO runs in ascending k order and LIFO in descending order.
// Optional feature macro DFC_PARAM_DIFF_EN enables cmd=3 (DIFF).
// DIFF streams |word[k] - word[k+DEPTH/2]| in ascending order.
// Without the macro, cmd=3 is ignored.
// Outputs are decoded only from registered state, index and buffer.
module dfc_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input logic        clk,
    input logic        reset_n,
    dfc_param_if.slave bus_io
);

    localparam int unsigned Half = DEPTH / 2;
    localparam logic [IDX_W-1:0] LastLoad = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] LastBeat = IDX_W'(Half - 1);
    localparam logic [IDX_W-1:0] HalfIdx  = IDX_W'(Half);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFifo,
        StLifo
`ifdef DFC_PARAM_DIFF_EN
        ,
        StDiff
`endif
    } state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]  lo_idx;
    logic [IDX_W-1:0]  hi_idx;
    logic [DATA_W-1:0] word_lo;
    logic [DATA_W-1:0] word_hi;
    logic [DATA_W:0]   pair_sum;
`ifdef DFC_PARAM_DIFF_EN
    logic [DATA_W:0]   pair_diff;
`endif

    // State, index and buffer. In read states idx_q counts transferred beats.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.cmd_valid) begin
                        idx_q <= '0;
                        case (bus_io.cmd)
                            2'd0:    state_q <= StLoad;
                            2'd1:    state_q <= StFifo;
                            2'd2:    state_q <= StLifo;
`ifdef DFC_PARAM_DIFF_EN
                            2'd3:    state_q <= StDiff;
`endif
                            default: state_q <= StIdle;
                        endcase
                    end
                end
                StLoad: begin
                    if (bus_io.data_valid) begin
                        mem_q[idx_q] <= bus_io.datain;
                        if (idx_q == LastLoad) begin
                            idx_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
`ifdef DFC_PARAM_DIFF_EN
                StFifo, StLifo, StDiff: begin
`else
                StFifo, StLifo: begin
`endif
                    // output_valid is always high here, so out_ready alone marks a transfer.
                    if (bus_io.out_ready) begin
                        if (idx_q == LastBeat) begin
                            idx_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    // Select the current pair. LIFO mirrors the beat count onto the pair index.
    always_comb begin
        lo_idx   = (state_q == StLifo) ? (LastBeat - idx_q) : idx_q;
        hi_idx   = lo_idx + HalfIdx;
        word_lo  = mem_q[lo_idx];
        word_hi  = mem_q[hi_idx];
        pair_sum = {1'b0, word_lo} + {1'b0, word_hi};
`ifdef DFC_PARAM_DIFF_EN
        pair_diff = (word_lo >= word_hi) ? {1'b0, word_lo - word_hi}
                                         : {1'b0, word_hi - word_lo};
`endif
    end

    // Output decode. dataout is forced to zero whenever output_valid is low.
    always_comb begin
        bus_io.busy         = (state_q != StIdle);
        bus_io.output_valid = 1'b0;
        bus_io.dataout      = '0;
        case (state_q)
            StFifo, StLifo: begin
                bus_io.output_valid = 1'b1;
                bus_io.dataout      = pair_sum;
            end
`ifdef DFC_PARAM_DIFF_EN
            StDiff: begin
                bus_io.output_valid = 1'b1;
                bus_io.dataout      = pair_diff;
            end
`endif
            default: begin
                bus_io.output_valid = 1'b0;
                bus_io.dataout      = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dfc_param.sv
// Directed bench for dfc_param with DATA_W=8 and DEPTH=8.
// Build with DFC_PARAM_DIFF_EN to cover the DIFF mode.
module tb_dfc_param;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    dfc_param_if #(.DATA_W(8)) bus ();

    dfc_param #(
        .DATA_W(8),
        .DEPTH (8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Abort if the run ever stops making progress.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [8:0] exp_up   [4] = '{9'd6, 9'd8, 9'd10, 9'd12};
    logic [8:0] exp_down [4] = '{9'd12, 9'd10, 9'd8, 9'd6};
    logic [8:0] exp_diff [4] = '{9'd7, 9'd7, 9'd0, 9'd255};
    logic [7:0] diff_words [8] = '{8'd10, 8'd2, 8'd7, 8'd0, 8'd3, 8'd9, 8'd7, 8'd255};

    // Advance one cycle. Inputs change, and outputs are sampled, 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic [1:0] c);
        bus.cmd       = c;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'd0;
    endtask

    task automatic load_word(input logic [7:0] w);
        bus.datain     = w;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        bus.datain     = '0;
        bus.data_valid = 1'b0;
        bus.cmd        = '0;
        bus.cmd_valid  = 1'b0;
        bus.out_ready  = 1'b1;
        #12;
        vectors++;
        if (bus.busy !== 1'b0 || bus.output_valid !== 1'b0 || bus.dataout !== 9'd0) begin
            miscompares++;
            $display("FAIL reset: busy=%b valid=%b dataout=%0d, expected 0/0/0",
                     bus.busy, bus.output_valid, bus.dataout);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Scenario 1: load 1..8, then FIFO yields 6,8,10,12.
    task automatic test_fifo();
        issue_cmd(2'd0);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (bus.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL load_busy[%0d]: busy=%b, expected 1", i, bus.busy);
            end
            load_word(8'(i + 1));
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL load_done: busy=%b, expected 0", bus.busy);
        end
        issue_cmd(2'd1);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bus.output_valid !== 1'b1 || bus.dataout !== exp_up[i]) begin
                miscompares++;
                $display("FAIL fifo[%0d]: valid=%b dataout=%0d, expected 1/%0d",
                         i, bus.output_valid, bus.dataout, exp_up[i]);
            end
            tick();
        end
        vectors++;
        if (bus.busy !== 1'b0 || bus.output_valid !== 1'b0 || bus.dataout !== 9'd0) begin
            miscompares++;
            $display("FAIL fifo_end: busy=%b valid=%b dataout=%0d, expected 0/0/0",
                     bus.busy, bus.output_valid, bus.dataout);
        end
    endtask

    // Scenario 2: LIFO runs in reverse order, then FIFO again shows the buffer is intact.
    task automatic test_lifo();
        issue_cmd(2'd2);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bus.output_valid !== 1'b1 || bus.dataout !== exp_down[i]) begin
                miscompares++;
                $display("FAIL lifo[%0d]: valid=%b dataout=%0d, expected 1/%0d",
                         i, bus.output_valid, bus.dataout, exp_down[i]);
            end
            tick();
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL lifo_end: busy=%b, expected 0", bus.busy);
        end
        issue_cmd(2'd1);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bus.dataout !== exp_up[i]) begin
                miscompares++;
                $display("FAIL refifo[%0d]: dataout=%0d, expected %0d",
                         i, bus.dataout, exp_up[i]);
            end
            tick();
        end
    endtask

    // Scenario 3: load all 255 with a 2-cycle stall. The load takes 10 cycles.
    // The FIFO readout keeps the carry.
    task automatic test_stall_carry();
        int cycles;
        cycles = 0;
        issue_cmd(2'd0);
        for (int i = 0; i < 3; i++) begin
            load_word(8'd255);
            cycles++;
        end
        for (int i = 0; i < 2; i++) begin
            bus.datain = 8'd0;
            tick();
            cycles++;
            vectors++;
            if (bus.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_busy[%0d]: busy=%b, expected 1", i, bus.busy);
            end
        end
        for (int i = 0; i < 5; i++) begin
            load_word(8'd255);
            cycles++;
        end
        vectors++;
        if (bus.busy !== 1'b0 || cycles != 10) begin
            miscompares++;
            $display("FAIL stall_load: busy=%b after %0d cycles, expected 0 after 10",
                     bus.busy, cycles);
        end
        issue_cmd(2'd1);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bus.dataout !== 9'd510) begin
                miscompares++;
                $display("FAIL carry[%0d]: dataout=%0d, expected 510", i, bus.dataout);
            end
            tick();
        end
    endtask

    // Scenario 4: backpressure at beat 1 holds the output. No beat is lost or duplicated.
    task automatic test_backpressure();
        issue_cmd(2'd0);
        for (int i = 0; i < 8; i++) load_word(8'(i + 1));
        issue_cmd(2'd1);
        vectors++;
        if (bus.dataout !== 9'd6) begin
            miscompares++;
            $display("FAIL bp_beat0: dataout=%0d, expected 6", bus.dataout);
        end
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus.output_valid !== 1'b1 || bus.dataout !== 9'd8) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: valid=%b dataout=%0d, expected 1/8",
                         i, bus.output_valid, bus.dataout);
            end
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            vectors++;
            if (bus.dataout !== exp_up[i]) begin
                miscompares++;
                $display("FAIL bp_resume[%0d]: dataout=%0d, expected %0d",
                         i, bus.dataout, exp_up[i]);
            end
            tick();
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_end: busy=%b, expected 0", bus.busy);
        end
    endtask

    // Scenario 5: asynchronous reset during a read and during a load.
    // Afterwards the buffer reads all zero, and commands issued while busy are ignored.
    task automatic test_reset_abort();
        issue_cmd(2'd1);
        tick();
        reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.output_valid !== 1'b0 || bus.dataout !== 9'd0) begin
            miscompares++;
            $display("FAIL rst_read: busy=%b valid=%b dataout=%0d, expected 0/0/0",
                     bus.busy, bus.output_valid, bus.dataout);
        end
        tick();
        reset_n = 1'b1;
        tick();
        issue_cmd(2'd0);
        for (int i = 0; i < 5; i++) load_word(8'(i + 1));
        reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.output_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_load: busy=%b valid=%b, expected 0/0",
                     bus.busy, bus.output_valid);
        end
        tick();
        reset_n = 1'b1;
        tick();
        issue_cmd(2'd1);
        for (int i = 0; i < 4; i++) begin
            // A LOAD command is presented while busy. It must have no effect.
            bus.cmd_valid = (i == 1 || i == 2);
            bus.cmd       = 2'd0;
            vectors++;
            if (bus.output_valid !== 1'b1 || bus.dataout !== 9'd0) begin
                miscompares++;
                $display("FAIL rst_zero[%0d]: valid=%b dataout=%0d, expected 1/0",
                         i, bus.output_valid, bus.dataout);
            end
            tick();
        end
        bus.cmd_valid = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_ignore: busy=%b, expected 0", bus.busy);
        end
    endtask

    // Scenario 6: cmd=3 gives DIFF results when enabled, and is ignored otherwise.
    task automatic test_diff();
        issue_cmd(2'd0);
        for (int i = 0; i < 8; i++) load_word(diff_words[i]);
        issue_cmd(2'd3);
`ifdef DFC_PARAM_DIFF_EN
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bus.output_valid !== 1'b1 || bus.dataout !== exp_diff[i]) begin
                miscompares++;
                $display("FAIL diff[%0d]: valid=%b dataout=%0d, expected 1/%0d",
                         i, bus.output_valid, bus.dataout, exp_diff[i]);
            end
            tick();
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL diff_end: busy=%b, expected 0", bus.busy);
        end
`else
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (bus.busy !== 1'b0 || bus.output_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL diff_off[%0d]: busy=%b valid=%b, expected 0/0",
                         i, bus.busy, bus.output_valid);
            end
            tick();
        end
        vectors++;
        if (exp_diff[0] !== 9'd7) begin
            miscompares++;
            $display("FAIL diff_table: entry=%0d, expected 7", exp_diff[0]);
        end
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_fifo();
        test_lifo();
        test_stall_carry();
        test_backpressure();
        test_reset_abort();
        test_diff();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dfc_param.md
Name: dfc_param

Overview:
Parametrised data-fetch/combine controller. Loads DEPTH unsigned words into an internal buffer, then streams DEPTH/2 pairwise results (word k combined with word k+DEPTH/2) in ascending or descending order. Successor to the fixed 8x8-bit controller, with these additions:
- generic width and depth
- input valid-gating during load
- output backpressure via out_ready
- an optional absolute-difference mode

Sits between the upstream sample source and the downstream accumulator/packer.

Parameters:
DATA_W, 8, width of each input word (unsigned).
DEPTH, 8, number of buffered words. Power of 2, >= 2.
IDX_W, $clog2(DEPTH), load/read index width. Derived; do not override.

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous active-low reset.
datain  input  DATA_W  load data word.
data_valid  input  1  datain qualifier; sampled only in LOAD.
cmd  input  2  0=LOAD, 1=FIFO sum, 2=LIFO sum, 3=DIFF (see Optional Feature).
cmd_valid  input  1  command strobe; sampled only in IDLE.
out_ready  input  1  downstream accepts dataout this cycle.
dataout  output  DATA_W+1  pair result, zero-extended unsigned.
output_valid  output  1  dataout is valid.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: the following are forced to 0 immediately and asynchronously while reset_n=0:
  - state=IDLE, load/read index=0, all buffer words=0
  - busy, output_valid and dataout all read 0.
- Reset mid-operation aborts the operation. The buffer is cleared; there is no partial retention.
- States:
  - IDLE: busy=0. On cmd_valid=1, go to LOAD/FIFO/LIFO/DIFF per cmd on the next edge; index=0.
  - cmd_valid while busy=1 is ignored; there is no queuing.
  - LOAD: datain is not sampled in the command cycle; the first capture happens in the following cycle.
    - Each cycle with data_valid=1: buf[index]<=datain, index++.
    - data_valid=0 stalls the load with no write.
    - After the DEPTH-th write, go to IDLE and index returns to 0.
  - FIFO: beat k (k=0..DEPTH/2-1) has dataout = buf[k] + buf[k+DEPTH/2]. Full DATA_W+1 sum, never truncated.
  - LIFO: same pair sums in descending order, k=DEPTH/2-1 down to 0.
- Output handshake:
  - output_valid=1 throughout FIFO/LIFO/DIFF.
  - A beat transfers on output_valid & out_ready; only then does the index advance.
  - With out_ready=0, dataout and the index hold unchanged.
  - After the final beat transfers, go to IDLE. busy=0 and output_valid=0 from the next cycle.
- Output timing: dataout, output_valid and busy are decoded combinationally from registered state, index and buffer only. No combinational path runs from any input to any output.
- Minimum latency, with out_ready held high:
  - cmd accepted at edge N; first beat valid in cycle N+1.
  - DEPTH/2 beats in DEPTH/2 cycles.
- dataout=0 whenever output_valid=0.
- Reading without a prior load returns pair results of the current buffer contents: all 0 after reset.
- A LOAD overwrites all DEPTH words. Readout does not modify the buffer, so repeated FIFO/LIFO commands return identical results.

Optional Feature:
Macro DFC_PARAM_DIFF_EN.
- Defined: cmd=3 enters DIFF.
  - Beat k (ascending order) has dataout = |buf[k] - buf[k+DEPTH/2]|, zero-extended, so MSB=0.
  - Same handshake and termination rules as FIFO.
- Undefined: cmd=3 with cmd_valid is ignored. The block stays in IDLE and busy stays 0.

Test Plan (DATA_W=8, DEPTH=8):
1. LOAD 1,2,...,8 with data_valid held high, then FIFO with out_ready=1 -> dataout 6,8,10,12 on 4 consecutive cycles; busy falls the cycle after the beat of 12.
2. Same buffer, then LIFO -> 12,10,8,6. Issue FIFO again -> 6,8,10,12, confirming the buffer is unchanged.
3. LOAD 255 into all words, with data_valid low for 2 cycles after word 3 -> load takes 10 cycles. FIFO -> 510 on every beat (9-bit carry kept).
4. Backpressure: FIFO on the test-1 data, out_ready=0 for 3 cycles at beat 1 -> dataout holds 8 and output_valid stays 1; sequence resumes 10,12 with no beat lost or duplicated.
5. reset_n pulsed low after 5 loaded words -> outputs 0 immediately. A subsequent FIFO gives 0,0,0,0. cmd_valid during busy is ignored.
6. DFC_PARAM_DIFF_EN defined: LOAD 10,2,7,0,3,9,7,255, then cmd=3 -> 7,7,0,255. Macro undefined: cmd=3 -> busy stays 0 and no output_valid.
